// File: rtl/kat_adc_ps_ctrl.sv
// MMCM dynamic phase-shift controller: steps psen/psincdec, tracks signed offset.
// Optional psdone timeout watchdog enabled by defining KAT_ADC_PS_TIMEOUT_EN.
module kat_adc_ps_ctrl #(
  parameter int STEP_W     = 10,
  parameter int OFS_W      = 16,
  parameter int MAX_OFFSET = 1120,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              mmcm_psclk,
  input  logic              ctrl_reset,
  input  logic              mmcm_locked,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_home,
  input  logic              err_clear,
  output logic              mmcm_psen,
  output logic              mmcm_psincdec,
  input  logic              mmcm_psdone,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err,
  output logic [OFS_W-1:0]  phase_offset
);

  localparam int REM_W = (OFS_W > STEP_W) ? OFS_W : STEP_W;
  localparam logic signed [OFS_W:0] MAX_S = (OFS_W+1)'(MAX_OFFSET);
  localparam logic signed [OFS_W:0] MIN_S = -MAX_S;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_DONE, GAP, FINISH
  } state_e;

  state_e                   state_q, state_d;
  logic                     dir_q, dir_d;
  logic                     incdec_q, incdec_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [3:0]               gap_q, gap_d;
  logic signed [OFS_W-1:0]  ofs_q, ofs_d;
  logic [2:0]               err_q, err_d;
`ifdef KAT_ADC_PS_TIMEOUT_EN
  logic [15:0]              tmo_q, tmo_d;
`endif

  logic                     accept;
  logic                     psen;
  logic                     done_p;
  logic                     range_bad;
  logic [OFS_W-1:0]         ofs_abs;
  logic signed [OFS_W:0]    ofs_ext, step_s, ofs_nxt;

  assign cmd_ready = (state_q == IDLE) && mmcm_locked && !ctrl_reset;
  assign accept    = cmd_valid && cmd_ready;
  assign ofs_abs   = ofs_q[OFS_W-1] ? $unsigned(-ofs_q) : $unsigned(ofs_q);
  assign ofs_ext   = {ofs_q[OFS_W-1], ofs_q};
  assign step_s    = dir_q ? (OFS_W+1)'(1) : '1;
  assign ofs_nxt   = ofs_ext + step_s;
  assign range_bad = (ofs_nxt > MAX_S) || (ofs_nxt < MIN_S);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    incdec_d = incdec_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    ofs_d    = ofs_q;
    err_d    = err_clear ? 3'b000 : err_q;
    psen     = 1'b0;
    done_p   = 1'b0;
`ifdef KAT_ADC_PS_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_home) begin
            dir_d = ofs_q[OFS_W-1];
            rem_d = REM_W'(ofs_abs);
          end else begin
            dir_d = cmd_dir;
            rem_d = REM_W'(cmd_steps);
          end
          state_d = (rem_d == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (range_bad) begin
          err_d[1] = 1'b1;
          state_d  = IDLE;
        end else begin
          psen     = 1'b1;
          incdec_d = dir_q;
          state_d  = WAIT_DONE;
`ifdef KAT_ADC_PS_TIMEOUT_EN
          tmo_d    = 16'd1;
`endif
        end
      end
      WAIT_DONE: begin
        if (mmcm_psdone) begin
          ofs_d = ofs_nxt[OFS_W-1:0];
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = FINISH;
          end else begin
            state_d = GAP;
            gap_d   = 4'(GAP_CYCLES - 1);
          end
        end
`ifdef KAT_ADC_PS_TIMEOUT_EN
        else if (tmo_q >= 16'(TIMEOUT - 1)) begin
          err_d[0] = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = ISSUE;
        else               gap_d   = gap_q - 4'd1;
      end
      FINISH: begin
        done_p  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A relock clears the MMCM phase shift, so the offset follows it to zero.
    if (!mmcm_locked) begin
      ofs_d  = '0;
      psen   = 1'b0;
      done_p = 1'b0;
      if (state_q != IDLE) begin
        err_d[2] = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge mmcm_psclk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      incdec_q <= 1'b0;
      rem_q    <= '0;
      gap_q    <= 4'd0;
      ofs_q    <= '0;
      err_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      incdec_q <= incdec_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      ofs_q    <= ofs_d;
      err_q    <= err_d;
    end
  end

`ifdef KAT_ADC_PS_TIMEOUT_EN
  always_ff @(posedge mmcm_psclk or posedge ctrl_reset) begin
    if (ctrl_reset) tmo_q <= 16'd0;
    else            tmo_q <= tmo_d;
  end
`endif

  assign mmcm_psen     = psen;
  assign mmcm_psincdec = (state_q == ISSUE) ? dir_q : incdec_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_p;
  assign err           = err_q;
  assign phase_offset  = ofs_q;

endmodule

// File: doc/kat_adc_ps_ctrl.md
# kat_adc_ps_ctrl

MMCM dynamic phase-shift controller for the KAT ADC capture clock. It accepts step commands from the control interface and drives the `mmcm_psen`/`mmcm_psincdec` pins of `kat_adc_wrapper` one step at a time, waiting for `mmcm_psdone` after each step. It keeps a signed running phase offset, range-checks every step and reports completion and errors back to software. It sits directly upstream of the wrapper's phase-shift port and runs in the `mmcm_psclk` domain.

## Interface
Parameters:
- `STEP_W`, 10, width of the command step count.
- `OFS_W`, 16, width of the signed phase-offset register.
- `MAX_OFFSET`, 1120, maximum allowed |phase_offset| in steps.
- `GAP_CYCLES`, 2, idle cycles between a `psdone` and the next `psen` (range 1..15).
- `TIMEOUT`, 255, cycles to wait for `psdone` before declaring a timeout (range 1..65535).

Ports:
- `mmcm_psclk`  in  1  clock; all logic is on its rising edge.
- `ctrl_reset`  in  1  asynchronous, active-high reset.
- `mmcm_locked`  in  1  MMCM lock status from the wrapper.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_dir`  in  1  1 = increment, 0 = decrement. Ignored when `cmd_home` is set.
- `cmd_steps`  in  STEP_W  number of steps. Ignored when `cmd_home` is set.
- `cmd_home`  in  1  return to offset 0.
- `err_clear`  in  1  clears the sticky error flags.
- `mmcm_psen`  out  1  phase-shift enable, one-cycle pulse per step.
- `mmcm_psincdec`  out  1  step direction; valid in the `psen` cycle.
- `mmcm_psdone`  in  1  step completion from the MMCM.
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle pulse on normal command completion.
- `err`  out  3  sticky flags: [0] timeout, [1] range, [2] lock lost.
- `phase_offset`  out  OFS_W  signed accumulated offset, in steps.

## Operation
- States are IDLE, ISSUE, WAIT_DONE, GAP and FINISH.
- `cmd_ready` = (state == IDLE) & `mmcm_locked`.
- On acceptance, the controller latches the direction and the remaining step count.
  - For `cmd_home`: remaining = |phase_offset|, and dir = 1 if phase_offset < 0, else 0.
- IDLE → ISSUE on accept when remaining > 0.
- IDLE → FINISH on accept when remaining == 0; no `psen` is issued.
- ISSUE performs a range check on the offset after the step (phase_offset ±1).
  - If the check fails (|new offset| > MAX_OFFSET): set err[1], abort to IDLE, and do not assert `done`.
  - Otherwise: assert `mmcm_psen` for exactly 1 cycle with `mmcm_psincdec` = dir, then go to WAIT_DONE.
- WAIT_DONE, on `mmcm_psdone`:
  - phase_offset ±1 (saturation is not needed because of the range check).
  - remaining −1.
  - Go to FINISH if remaining is now 0, else go to GAP.
- GAP waits GAP_CYCLES cycles, then goes to ISSUE.
- FINISH pulses `done` for 1 cycle, then goes to IDLE.
- `mmcm_psdone` is ignored in every state except WAIT_DONE.
- `mmcm_locked` low in any non-IDLE state:
  - Abort to IDLE on the next edge, set err[2], no `done`.
  - phase_offset is forced to 0, because an MMCM relock clears the phase shift.
- `mmcm_locked` low in IDLE also forces phase_offset to 0. err[2] is not set in this case.
- `err_clear` zeroes all err bits. A new error setting in the same cycle wins for that bit.
- `busy` = state != IDLE.

## Timing
- Reset values: `cmd_ready` 0, `mmcm_psen` 0, `mmcm_psincdec` 0, `busy` 0, `done` 0, `err` 0, `phase_offset` 0, state IDLE.
- Accept at edge N → `mmcm_psen` high in cycle N+1.
- `psdone` sampled at edge M:
  - phase_offset is updated in cycle M+1.
  - The next `psen` is in cycle M+1+GAP_CYCLES.
  - Or, if this was the last step, `done` is in cycle M+1.
- A zero-step command (or home at offset 0) gives `done` in cycle N+1.
- `mmcm_psincdec` holds its value from ISSUE until the next ISSUE.
- `ctrl_reset` mid-command returns every output to its reset value immediately, without waiting for a clock edge.

## Configuration
- `KAT_ADC_PS_TIMEOUT_EN`, defined:
  - A counter starts in the `psen` cycle.
  - If TIMEOUT cycles elapse in WAIT_DONE without `psdone`: set err[0], abort to IDLE, no `done`, and leave phase_offset unchanged.
- `KAT_ADC_PS_TIMEOUT_EN`, undefined:
  - WAIT_DONE waits indefinitely.
  - err[0] is tied to 0 and no counter logic is present.

## Test plan
- Locked; cmd inc, steps=3; psdone 12 cycles after each psen → exactly 3 psen pulses with psincdec=1, phase_offset=3, one `done` pulse, err=0.
- Offset 3; cmd_home → 3 psen pulses with psincdec=0, phase_offset=0, `done`. A second home → `done` 1 cycle after accept, no psen.
- MAX_OFFSET=4, offset 3; cmd inc, steps=3 → 1 psen, offset 4, then err[1]=1, no `done`, back to IDLE. err_clear → err=0.
- Mid-command (step 2 of 5), drop mmcm_locked → abort, err[2]=1, phase_offset=0, cmd_ready stays 0 until relock.
- With `KAT_ADC_PS_TIMEOUT_EN`, TIMEOUT=20, psdone withheld → err[0]=1 at 20 cycles after psen, offset unchanged, busy=0. Without the macro → busy stays 1 after 1000 cycles.
- Spurious psdone pulses in IDLE and GAP → phase_offset unchanged, no extra psen.
